// File: rtl/inst_rom_arbiter.sv
// Two-requester arbiter for the shared combinational instruction ROM port.
// m0 (fetch) has fixed priority; m1 is forced through after MAX_WAIT back-to-back m0 wins.
module inst_rom_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 17,
  parameter int MAX_WAIT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_ack,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_ack,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic              stallreq_if,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst
);

  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);
  localparam logic [WCW-1:0] WAIT_ONE = WCW'(1);

  // Address is in range when every bit above the word index is zero.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return ((a >> (DEPTH_LOG2 + 2)) == {ADDR_W{1'b0}});
  endfunction

  logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
  logic              m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
  logic              m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;
  logic [31:0]       m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

  logic              grant_m0_s, grant_m1_s, win_in_range_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [31:0]       win_data_s;

  // Arbitration, ROM drive and stall request; everything is gated off while in reset.
  always_comb begin
    grant_m0_s     = 1'b0;
    grant_m1_s     = 1'b0;
    win_addr_s     = {ADDR_W{1'b0}};
    win_in_range_s = 1'b0;
    rom_ce         = 1'b0;
    rom_addr       = {ADDR_W{1'b0}};
    stallreq_if    = 1'b0;
    if (rst && m1_req && (!m0_req || (wait_cnt_q == WAIT_MAX))) begin
      grant_m1_s = 1'b1;
    end else if (rst && m0_req) begin
      grant_m0_s = 1'b1;
    end else begin
      grant_m0_s = 1'b0;
      grant_m1_s = 1'b0;
    end
    if (grant_m1_s) begin
      win_addr_s = m1_addr;
    end else begin
      win_addr_s = m0_addr;
    end
    win_in_range_s = addr_in_range(win_addr_s);
    if ((grant_m0_s || grant_m1_s) && win_in_range_s) begin
      rom_ce   = 1'b1;
      rom_addr = win_addr_s;
    end else begin
      rom_ce   = 1'b0;
      rom_addr = {ADDR_W{1'b0}};
    end
    stallreq_if = rst & m0_req & ~grant_m0_s;
  end

  // Next-state for the response registers and the m1 starvation counter.
  always_comb begin
    if (win_in_range_s) begin
      win_data_s = rom_inst;
    end else begin
      win_data_s = 32'd0;
    end
    m0_ack_d   = grant_m0_s;
    m1_ack_d   = grant_m1_s;
    m0_err_d   = grant_m0_s & ~win_in_range_s;
    m1_err_d   = grant_m1_s & ~win_in_range_s;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    if (grant_m0_s) begin
      m0_rdata_d = win_data_s;
    end else begin
      m0_rdata_d = m0_rdata_q;
    end
    if (grant_m1_s) begin
      m1_rdata_d = win_data_s;
    end else begin
      m1_rdata_d = m1_rdata_q;
    end
    if (grant_m1_s || !m1_req) begin
      wait_cnt_d = {WCW{1'b0}};
    end else if (grant_m0_s && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + WAIT_ONE;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // State registers; a reset edge drops any response that was about to be delivered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_q <= {WCW{1'b0}};
      m0_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m0_rdata_q <= 32'd0;
      m1_ack_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m1_rdata_q <= 32'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      m0_ack_q   <= m0_ack_d;
      m0_err_q   <= m0_err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_ack_q   <= m1_ack_d;
      m1_err_q   <= m1_err_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign m0_ack   = m0_ack_q;
  assign m0_err   = m0_err_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_ack   = m1_ack_q;
  assign m1_err   = m1_err_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: doc/inst_rom_arbiter.md
Name: inst_rom_arbiter

Overview:
- Shares the single combinational instruction ROM port (ce/addr -> inst) between two requesters.
- m0 is the IF-stage fetch port. m1 is a secondary read port (data-side lw from code space or loader/debug readback).
- Fixed priority to m0, with a starvation guard for m1. Registered one-cycle response per grant. Exports a stall request to the pipeline controller while m0 is waiting.

Parameters:
- ADDR_W, 32, requester/ROM address width
- DEPTH_LOG2, 17, log2 of ROM word count; ROM is indexed by addr[DEPTH_LOG2+1:2]
- MAX_WAIT, 4, max consecutive m0 grants while m1 is pending before m1 is forced

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-low reset (0 = reset, sampled on clk rising edge)
- m0_req  in  1  fetch request, held until m0_ack
- m0_addr  in  ADDR_W  fetch byte address, stable while m0_req=1
- m0_ack  out  1  one-cycle pulse: m0_rdata valid
- m0_rdata  out  32  fetched word
- m0_err  out  1  qualifies m0_ack: address out of ROM range
- m1_req  in  1  secondary request, held until m1_ack
- m1_addr  in  ADDR_W  secondary byte address
- m1_ack  out  1  one-cycle pulse: m1_rdata valid
- m1_rdata  out  32  read word
- m1_err  out  1  qualifies m1_ack: out of range
- stallreq_if  out  1  to pipeline control: m0_req=1 and m0 not granted this cycle
- rom_ce  out  1  ROM chip enable (1 = enable)
- rom_addr  out  ADDR_W  ROM address (winner's address passed through)
- rom_inst  in  32  ROM combinational read data

Behaviour:
- Reset (rst=0 at clk edge):
  - m0_ack, m1_ack, m0_err, m1_err = 0; m0_rdata, m1_rdata = 0; wait_cnt = 0.
  - rom_ce and all grants are forced to 0 combinationally while rst=0.
- Arbitration (combinational, each cycle):
  - Grant m1 if m1_req and (not m0_req, or wait_cnt == MAX_WAIT).
  - Otherwise grant m0 if m0_req.
  - Otherwise no grant.
- Range check: winner is in range iff addr[ADDR_W-1:DEPTH_LOG2+2] == 0. addr[1:0] is ignored (no alignment fault).
- ROM drive:
  - rom_ce = 1 only when a grant exists and the address is in range; then rom_addr = winner's addr.
  - Otherwise rom_ce = 0 and rom_addr = 0.
- Response: at the clk edge ending the grant cycle N, the winner's:
  - rdata <= rom_inst (in range) or 0 (out of range);
  - err <= out-of-range;
  - ack <= 1 for cycle N+1.
  - The loser's ack and err are 0 in N+1; its rdata holds its last value.
- Latency: exactly 1 cycle from grant to ack. Throughput: one access per cycle total.
- Back-to-back: req=1 in the cycle the requester's ack=1 is a new request, eligible for grant that same cycle. Requester updates addr/req combinationally from ack. IF sequential fetch therefore sustains 1 word/cycle.
- wait_cnt (0..MAX_WAIT, saturating), updated at clk edge:
  - Increment when m0 granted and m1_req=1.
  - Clear when m1 granted or m1_req=0.
  - Hold otherwise.
- stallreq_if = m0_req & ~grant_m0, combinational. It is 0 during reset.
- Simultaneous events:
  - Both requesting with wait_cnt < MAX_WAIT: m0 wins.
  - At MAX_WAIT: m1 wins once, then the counter clears.
- Reset mid-operation: an ack scheduled for the next cycle is dropped (ack=0). Requesters must reissue.
- Requests are not queued. The arbiter stores no address; requesters hold their inputs until ack.

Test Plan:
- Reset: rst=0 for 2 cycles with m0_req=1, m0_addr=0x0 -> rom_ce=0, m0_ack=0, stallreq_if=0, rdata=0. rst=1 -> first ack one cycle later.
- Sequential fetch: ROM[0..3]=0x34011100,0x34020020,0x3403ff00,0x3404ffff; m0 walks 0x0,0x4,0x8,0xC on each ack -> four consecutive acks with those words, stallreq_if=0 throughout.
- Contention, MAX_WAIT=4: m0 and m1 both requesting continuously, m1_addr=0x10 -> 4 m0 acks, then 1 m1 ack (data ROM[4]), pattern repeats; stallreq_if=1 exactly in each m1 grant cycle.
- m1 alone: m1_req=1, m1_addr=0x8, m0_req=0 -> rom_ce=1, rom_addr=0x8, m1_ack next cycle with ROM[2], wait_cnt=0.
- Out of range: m0_addr=0x0008_0000 (DEPTH_LOG2=17) -> rom_ce=0, m0_ack=1 with m0_err=1, m0_rdata=0; next in-range access has err=0.
- Reset mid-access: m1 granted in cycle N, rst=0 at edge ending N -> no m1_ack in N+1, wait_cnt=0, outputs zero.
